alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Sits in front of the 32-bit combinational ALU in the datapath, on the control side of its ALUCntrl/flag interface.
- Accepts one decoded MIPS-style instruction per valid/ready handshake, maps opcode/funct to the 4-bit ALU control code and drives the ALU operands.
- Captures ALU result and flags, and returns them on a registered valid/ready response.
- Builds operations the ALU lacks: SLT/SLTU from subtract flags, and a multi-bit SLL by iterating the ALU's shift-by-1.

Parameters:
- none (data width fixed at 32)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when high together with in_valid
- in_opcode  in  6  instruction opcode
- in_funct  in  6  R-type funct
- in_shamt  in  5  shift amount
- in_rs  in  32  rs operand value
- in_rt  in  32  rt operand value
- in_imm  in  16  I-type immediate
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_cntrl  out  4  to ALU ALUCntrl
- alu_out  in  32  from ALU ALU_Out
- alu_c, alu_v, alu_n, alu_z  in  1 each  from ALU flags
- res_valid  out  1  response valid
- res_ready  in  1  response consumed when high together with res_valid
- res_data  out  32  result
- res_c, res_v, res_n, res_z  out  1 each  result flags
- res_illegal  out  1  unsupported instruction
- res_ovf  out  1  signed overflow on add/sub/addi

Behaviour:
- Reset is asynchronous and active-low, with one clock. On reset: state=IDLE, all outputs 0, alu_cntrl=4'b0000. Reset mid-operation aborts it and produces no response.
- States:
  - IDLE: in_ready=1. On in_valid, latch the request.
    - Legal request: load alu_a/alu_b/alu_cntrl and go to EXEC.
    - Illegal request: go to RESP with res_illegal=1 and all data/flags 0.
  - EXEC: ALU is combinational. At the clock edge, sample alu_out and flags into the result registers.
    - Shift op with remaining count >1: alu_a<=alu_out, decrement the count, stay in EXEC.
    - Otherwise go to RESP.
  - RESP: res_valid=1. Result is held stable until res_ready=1, then go to IDLE. in_ready=0 outside IDLE.
- Latency from the accept edge:
  - Ordinary op: res_valid rises 2 edges after accept.
  - SLL with shamt n>=1: 1+n edges.
  - Illegal: 1 edge.
- Decode, R-type (opcode 0x00), A=rs, B=rt:
  - 0x20 add 1010; 0x21 addu 0010; 0x22 sub 1110; 0x23 subu 0110
  - 0x24 and 0000; 0x25 or 0001; 0x26 xor 0011; 0x27 nor 1100
  - 0x2A slt 1110; 0x2B sltu 0110
  - 0x00 sll: A=rt, cntrl 1101 repeated shamt times
- Decode, I-type, A=rs, B=imm:
  - 0x08 addi 1010 sext; 0x09 addiu 0010 sext; 0x0A slti 1110 sext; 0x0B sltiu 0110 sext
  - 0x0C andi 0000 zext; 0x0D ori 0001 zext; 0x0E xori 0011 zext
- Any other opcode/funct is illegal.
- Flag rules:
  - Logical ops: res_c=res_v=0 (ALU gives x); res_n, res_z from ALU.
  - add/sub/addi: flags from ALU; res_ovf=alu_v. Data is the wrapped sum. All other ops: res_ovf=0.
  - slt/slti: lt=alu_n^alu_v. sltu/sltiu: lt=alu_c (borrow).
  - Any set-less-than op: res_data={31'b0,lt}, res_z=~lt, res_c=res_v=res_n=0.
  - SLL: res_c is the last bit shifted out; res_v=0.
- SLL with shamt=0: one EXEC cycle with cntrl 0001, A=rt, B=0; res_data=rt, res_c=0.
- Response registers never change while res_valid=1 and res_ready=0.
- A new request is accepted no earlier than the cycle after a response handshake (no overlap).

Optional Feature:
- Macro ALU_SEQ_SHIFT_EN.
- Defined: sll supported as above (iterative, 1 ALU cycle per bit).
- Undefined: R-type funct 0x00 is decoded as illegal, and no shift counter exists.

Test Plan:
- add rs=0x7FFFFFFF rt=0x00000001 -> res_data=0x80000000, res_ovf=1, res_v=1, res_n=1, res_valid 2 edges after accept.
- sltu rs=0x00000001 rt=0xFFFFFFFF -> res_data=1, res_z=0. Same operands as slt -> res_data=0, res_z=1.
- sll rt=0xC0000001 shamt=3 -> res_data=0x00000008, res_c=0, 4 edges to res_valid. shamt=0 -> res_data=0xC0000001.
- andi rs=0xFFFF1234 imm=0xF0F0 -> res_data=0x00001030, res_c=res_v=0. addi rs=5 imm=0xFFFF -> res_data=4.
- opcode 0x23 (lw) -> res_illegal=1, res_data=0, res_valid 1 edge after accept. Hold res_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- Assert rst_n=0 during a 10-step shift -> all outputs 0 immediately. After release: in_ready=1, and no stale response appears.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Control-side sequencer for the 32-bit combinational ALU: decodes one instruction per
// handshake, drives the ALU and returns result/flags. ALU_SEQ_SHIFT_EN enables iterative SLL.
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [15:0] in_imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_cntrl,
  input  logic [31:0] alu_out,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        alu_z,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_c,
  output logic        res_v,
  output logic        res_n,
  output logic        res_z,
  output logic        res_illegal,
  output logic        res_ovf
);
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_e;
  typedef enum logic [2:0] {K_ARS, K_ARU, K_LOG, K_SLT, K_SLTU, K_SLL} kind_e;

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic            in_ready_q, in_ready_d;
  logic [DW-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [CW-1:0]   alu_cntrl_q, alu_cntrl_d;
  logic            res_valid_q, res_valid_d;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic            res_c_q, res_c_d, res_v_q, res_v_d, res_n_q, res_n_d, res_z_q, res_z_d;
  logic            res_illegal_q, res_illegal_d, res_ovf_q, res_ovf_d;
`ifdef ALU_SEQ_SHIFT_EN
  logic [SW-1:0]   cnt_q, cnt_d;
`else
  logic            shamt_unused;
  assign shamt_unused = ^in_shamt;
`endif

  logic            dec_legal;
  kind_e           dec_kind;
  logic [CW-1:0]   dec_cntrl;
  logic [DW-1:0]   dec_a, dec_b, sext_imm, zext_imm;
  logic [DW-1:0]   ex_data;
  logic            ex_c, ex_v, ex_n, ex_z, ex_ovf, lt;

  // Instruction decode to ALU control code, operands and result kind
  always_comb begin
    sext_imm  = {{16{in_imm[15]}}, in_imm};
    zext_imm  = {16'h0000, in_imm};
    dec_legal = 1'b1;
    dec_kind  = K_LOG;
    dec_cntrl = 4'b0000;
    dec_a     = in_rs;
    dec_b     = in_rt;
    case (in_opcode)
      6'h00: begin
        case (in_funct)
          6'h20: begin dec_cntrl = 4'b1010; dec_kind = K_ARS;  end
          6'h21: begin dec_cntrl = 4'b0010; dec_kind = K_ARU;  end
          6'h22: begin dec_cntrl = 4'b1110; dec_kind = K_ARS;  end
          6'h23: begin dec_cntrl = 4'b0110; dec_kind = K_ARU;  end
          6'h24: dec_cntrl = 4'b0000;
          6'h25: dec_cntrl = 4'b0001;
          6'h26: dec_cntrl = 4'b0011;
          6'h27: dec_cntrl = 4'b1100;
          6'h2A: begin dec_cntrl = 4'b1110; dec_kind = K_SLT;  end
          6'h2B: begin dec_cntrl = 4'b0110; dec_kind = K_SLTU; end
`ifdef ALU_SEQ_SHIFT_EN
          // shamt=0 degenerates to rt|0, which behaves exactly like a logical op
          6'h00: begin
            dec_a = in_rt;
            dec_b = '0;
            if (in_shamt == '0) begin
              dec_cntrl = 4'b0001;
              dec_kind  = K_LOG;
            end else begin
              dec_cntrl = 4'b1101;
              dec_kind  = K_SLL;
            end
          end
`endif
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin dec_b = sext_imm; dec_cntrl = 4'b1010; dec_kind = K_ARS;  end
      6'h09: begin dec_b = sext_imm; dec_cntrl = 4'b0010; dec_kind = K_ARU;  end
      6'h0A: begin dec_b = sext_imm; dec_cntrl = 4'b1110; dec_kind = K_SLT;  end
      6'h0B: begin dec_b = sext_imm; dec_cntrl = 4'b0110; dec_kind = K_SLTU; end
      6'h0C: begin dec_b = zext_imm; dec_cntrl = 4'b0000; end
      6'h0D: begin dec_b = zext_imm; dec_cntrl = 4'b0001; end
      6'h0E: begin dec_b = zext_imm; dec_cntrl = 4'b0011; end
      default: dec_legal = 1'b0;
    endcase
  end

  // Result shaping from the ALU outputs for the operation in flight
  always_comb begin
    ex_data = alu_out;
    ex_c    = alu_c;
    ex_v    = alu_v;
    ex_n    = alu_n;
    ex_z    = alu_z;
    ex_ovf  = 1'b0;
    lt      = (kind_q == K_SLT) ? (alu_n ^ alu_v) : alu_c;
    case (kind_q)
      K_ARS:  ex_ovf = alu_v;
      K_ARU:  ex_ovf = 1'b0;
      K_LOG:  begin ex_c = 1'b0; ex_v = 1'b0; end
      K_SLT, K_SLTU: begin
        ex_data = {{(DW-1){1'b0}}, lt};
        ex_z    = ~lt;
        ex_c    = 1'b0;
        ex_v    = 1'b0;
        ex_n    = 1'b0;
      end
      K_SLL:  ex_v = 1'b0;
      default: ex_ovf = 1'b0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_cntrl_d   = alu_cntrl_q;
    res_data_d    = res_data_q;
    res_c_d       = res_c_q;
    res_v_d       = res_v_q;
    res_n_d       = res_n_q;
    res_z_d       = res_z_q;
    res_illegal_d = res_illegal_q;
    res_ovf_d     = res_ovf_q;
`ifdef ALU_SEQ_SHIFT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (dec_legal) begin
            alu_a_d     = dec_a;
            alu_b_d     = dec_b;
            alu_cntrl_d = dec_cntrl;
            kind_d      = dec_kind;
`ifdef ALU_SEQ_SHIFT_EN
            cnt_d       = in_shamt;
`endif
            state_d     = S_EXEC;
          end else begin
            res_data_d    = '0;
            res_c_d       = 1'b0;
            res_v_d       = 1'b0;
            res_n_d       = 1'b0;
            res_z_d       = 1'b0;
            res_ovf_d     = 1'b0;
            res_illegal_d = 1'b1;
            state_d       = S_RESP;
          end
        end
      end
      S_EXEC: begin
        res_data_d    = ex_data;
        res_c_d       = ex_c;
        res_v_d       = ex_v;
        res_n_d       = ex_n;
        res_z_d       = ex_z;
        res_ovf_d     = ex_ovf;
        res_illegal_d = 1'b0;
        state_d       = S_RESP;
`ifdef ALU_SEQ_SHIFT_EN
        // Feed the shifted value back for another shift-by-1 pass
        if (kind_q == K_SLL && cnt_q > SW'(1)) begin
          alu_a_d = alu_out;
          cnt_d   = cnt_q - SW'(1);
          state_d = S_EXEC;
        end
`endif
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    res_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      kind_q        <= K_ARS;
      in_ready_q    <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_cntrl_q   <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_c_q       <= 1'b0;
      res_v_q       <= 1'b0;
      res_n_q       <= 1'b0;
      res_z_q       <= 1'b0;
      res_illegal_q <= 1'b0;
      res_ovf_q     <= 1'b0;
`ifdef ALU_SEQ_SHIFT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      in_ready_q    <= in_ready_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_cntrl_q   <= alu_cntrl_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_c_q       <= res_c_d;
      res_v_q       <= res_v_d;
      res_n_q       <= res_n_d;
      res_z_q       <= res_z_d;
      res_illegal_q <= res_illegal_d;
      res_ovf_q     <= res_ovf_d;
`ifdef ALU_SEQ_SHIFT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cntrl   = alu_cntrl_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_c       = res_c_q;
  assign res_v       = res_v_q;
  assign res_n       = res_n_q;
  assign res_z       = res_z_q;
  assign res_illegal = res_illegal_q;
  assign res_ovf     = res_ovf_q;
endmodule
